// File: rtl/apb_xip_read_cache.sv
// Direct-mapped, one-word-per-line read cache between an APB requester and the SPI flash APB slave.
// Optional XIP_CACHE_FLUSH_EN adds a synchronous flush input that invalidates every line.
module apb_xip_read_cache #(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
    parameter int          LINE_NUM   = 16
) (
    input  logic        clock,
    input  logic        reset,
`ifdef XIP_CACHE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);
    localparam int IDX   = $clog2(LINE_NUM);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state_reg, state_next;

    logic [31:0] addr_reg;
    logic        write_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  strb_reg;
    logic [2:0]  prot_reg;
    logic        flash_reg;
    logic [31:0] rdata_reg;
    logic        slverr_reg;

    logic [LINE_NUM-1:0] valid_reg;
    logic [LINE_NUM-1:0] valid_next;
    logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
    logic [31:0]         data_mem [LINE_NUM];

    logic             flush_int;
    logic             access;
    logic             in_flash;
    logic [IDX-1:0]   in_idx;
    logic [TAG_W-1:0] in_tag;
    logic             hit;
    logic             local_answer;
    logic [IDX-1:0]   fill_idx;
    logic             fill_en;

`ifdef XIP_CACHE_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    assign access       = in_psel & in_penable;
    assign in_flash     = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
    assign in_idx       = in_paddr[IDX+1:2];
    assign in_tag       = in_paddr[31:IDX+2];
    assign hit          = valid_reg[in_idx] && (tag_mem[in_idx] == in_tag);
    // Hits and rejected flash writes never touch the downstream bus.
    assign local_answer = in_flash && (in_pwrite || hit);

    // Error responses are not cached; a coincident flush wins over the fill.
    assign fill_idx = addr_reg[IDX+1:2];
    assign fill_en  = (state_reg == ACCESS) && out_pready && flash_reg && !write_reg
                      && !out_pslverr && !flush_int;

    generate
        for (genvar gi = 0; gi < LINE_NUM; gi++) begin : g_valid
            assign valid_next[gi] = flush_int ? 1'b0 :
                                    (fill_en && (fill_idx == IDX'(gi))) ? 1'b1 :
                                    valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            valid_reg <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= addr_reg[31:IDX+2];
            data_mem[fill_idx] <= out_prdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            wdata_reg  <= '0;
            strb_reg   <= '0;
            prot_reg   <= '0;
            flash_reg  <= 1'b0;
            rdata_reg  <= '0;
            slverr_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        addr_reg  <= in_paddr;
                        write_reg <= in_pwrite;
                        wdata_reg <= in_pwdata;
                        strb_reg  <= in_pstrb;
                        prot_reg  <= in_pprot;
                        flash_reg <= in_flash;
                        if (in_flash && in_pwrite) begin
                            rdata_reg  <= '0;
                            slverr_reg <= 1'b1;
                        end else if (in_flash && hit) begin
                            rdata_reg  <= data_mem[in_idx];
                            slverr_reg <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (out_pready) begin
                        rdata_reg  <= out_prdata;
                        slverr_reg <= out_pslverr;
                    end
                end
                RESP: begin
                    rdata_reg  <= '0;
                    slverr_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state_reg;
        out_psel    = 1'b0;
        out_penable = 1'b0;
        out_paddr   = '0;
        out_pprot   = '0;
        out_pwrite  = 1'b0;
        out_pwdata  = '0;
        out_pstrb   = '0;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    state_next = local_answer ? RESP : SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
                out_psel   = 1'b1;
            end
            ACCESS: begin
                out_psel    = 1'b1;
                out_penable = 1'b1;
                if (out_pready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (out_psel) begin
            out_paddr  = addr_reg;
            out_pprot  = prot_reg;
            out_pwrite = write_reg;
            out_pwdata = write_reg ? wdata_reg : 32'h0;
            out_pstrb  = write_reg ? strb_reg : 4'h0;
        end
    end

    assign in_pready  = (state_reg == RESP);
    assign in_prdata  = rdata_reg;
    assign in_pslverr = slverr_reg;

endmodule
